// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the pipelined IEEE-754 comparator: predicate codes,
// the per-operand classification record and the predicate/flag evaluators.
package fp_cmp_pkg;

    typedef logic [2:0] fp_op_t;

    localparam fp_op_t OP_EQ  = 3'd0;
    localparam fp_op_t OP_NE  = 3'd1;
    localparam fp_op_t OP_LT  = 3'd2;
    localparam fp_op_t OP_LE  = 3'd3;
    localparam fp_op_t OP_GT  = 3'd4;
    localparam fp_op_t OP_GE  = 3'd5;
    localparam fp_op_t OP_UN  = 3'd6;
    localparam fp_op_t OP_ORD = 3'd7;

    typedef struct packed {
        logic is_nan;
        logic is_snan;
        logic is_zero;
        logic sign;
    } fp_class_t;

    // Predicate result from the ordered relation (lt/eq) and the unordered flag.
    // Any NaN makes every relational predicate false except NE and UN.
    function automatic logic fp_predicate(input fp_op_t op, input logic unord,
                                          input logic lt, input logic eq);
        logic z;
        case (op)
            OP_EQ:   z = ~unord & eq;
            OP_NE:   z = unord | ~eq;
            OP_LT:   z = ~unord & lt;
            OP_LE:   z = ~unord & (lt | eq);
            OP_GT:   z = ~unord & ~lt & ~eq;
            OP_GE:   z = ~unord & ~lt;
            OP_UN:   z = unord;
            OP_ORD:  z = ~unord;
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    // Invalid-operation flag: ordering predicates trap on any NaN, the
    // equality/unordered family only on a signalling NaN.
    function automatic logic fp_invalid(input fp_op_t op, input logic any_nan,
                                        input logic any_snan);
        logic inv;
        case (op)
            OP_LT, OP_LE, OP_GT, OP_GE: inv = any_nan;
            default:                    inv = any_snan;
        endcase
        return inv;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classification of one IEEE-754 style operand of any
// exponent/mantissa width. Infinity is not flagged: it orders as a magnitude.
module fp_classify
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op_i,
    output fp_class_t            cls_o
);

    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] man_s;
    logic             exp_ones_s;
    logic             man_nz_s;

    assign exp_s      = op_i[EXP_W+MAN_W-1:MAN_W];
    assign man_s      = op_i[MAN_W-1:0];
    assign exp_ones_s = &exp_s;
    assign man_nz_s   = |man_s;

    assign cls_o.is_nan  = exp_ones_s & man_nz_s;
    // Quiet bit is the mantissa MSB; a NaN with it clear is signalling.
    assign cls_o.is_snan = exp_ones_s & man_nz_s & ~man_s[MAN_W-1];
    assign cls_o.is_zero = ~(|exp_s) & ~man_nz_s;
    assign cls_o.sign    = op_i[EXP_W+MAN_W];

endmodule

// File: rtl/fp_cmp_pipe.sv
// Pipelined parametrised IEEE-754 comparator with eight predicates, an
// unordered flag and valid/ready backpressure (one global stage enable).
// Optional macro FP_CMP_INVALID_FLAG_EN adds the out_invalid output.
module fp_cmp_pipe
    import fp_cmp_pkg::*;
#(
    parameter  int EXP_W  = 8,
    parameter  int MAN_W  = 23,
    parameter  int STAGES = 2,
    localparam int W      = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_z,
    output logic         out_unordered
`ifdef FP_CMP_INVALID_FLAG_EN
    ,
    output logic         out_invalid
`endif
);

    logic      en_s;
    fp_class_t cls_a_s;
    fp_class_t cls_b_s;
    logic      mag_lt_s;
    logic      mag_eq_s;

    // Stage 1 registers
    logic      s1_valid_q;
    fp_class_t s1_cls_a_q;
    fp_class_t s1_cls_b_q;
    logic      s1_mag_lt_q;
    logic      s1_mag_eq_q;
    fp_op_t    s1_op_q;

    // Result stage (index 2) followed by pure delay stages up to STAGES
    logic [STAGES:2] res_valid_q;
    logic [STAGES:2] res_z_q;
    logic [STAGES:2] res_un_q;
    logic            lt_s;
    logic            eq_s;
    logic            un_d;
    logic            z_d;
`ifdef FP_CMP_INVALID_FLAG_EN
    logic [STAGES:2] res_inv_q;
    logic            inv_d;
`else
    logic            unused_snan_s;
    assign unused_snan_s = s1_cls_a_q.is_snan | s1_cls_b_q.is_snan;
`endif

    // Whole pipe advances together; it stalls only when the output is full and refused.
    assign en_s     = ~out_valid | out_ready;
    assign in_ready = en_s & ~rst;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.op_i(in_a), .cls_o(cls_a_s));
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.op_i(in_b), .cls_o(cls_b_s));

    // {exp,man} as one unsigned magnitude orders every non-NaN value incl. inf and denormals.
    assign mag_lt_s = in_a[W-2:0] <  in_b[W-2:0];
    assign mag_eq_s = in_a[W-2:0] == in_b[W-2:0];

    // Stage 1 valid bit: the only stage-1 state that reset clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (en_s) begin
            s1_valid_q <= in_valid;
        end else begin
            s1_valid_q <= s1_valid_q;
        end
    end

    // Stage 1 data: classification, signs, magnitude compare and op (not reset).
    always_ff @(posedge clk) begin
        if (en_s) begin
            s1_cls_a_q  <= cls_a_s;
            s1_cls_b_q  <= cls_b_s;
            s1_mag_lt_q <= mag_lt_s;
            s1_mag_eq_q <= mag_eq_s;
            s1_op_q     <= fp_op_t'(in_op);
        end else begin
            s1_cls_a_q  <= s1_cls_a_q;
            s1_cls_b_q  <= s1_cls_b_q;
            s1_mag_lt_q <= s1_mag_lt_q;
            s1_mag_eq_q <= s1_mag_eq_q;
            s1_op_q     <= s1_op_q;
        end
    end

    // Ordered relation from stage-1 facts, then predicate and flags.
    always_comb begin
        un_d = s1_cls_a_q.is_nan | s1_cls_b_q.is_nan;
        if (s1_cls_a_q.is_zero && s1_cls_b_q.is_zero) begin
            lt_s = 1'b0;
            eq_s = 1'b1;
        end else if (s1_cls_a_q.sign != s1_cls_b_q.sign) begin
            lt_s = s1_cls_a_q.sign;
            eq_s = 1'b0;
        end else if (s1_cls_a_q.sign) begin
            // Both negative: larger magnitude is the smaller value.
            lt_s = ~s1_mag_lt_q & ~s1_mag_eq_q;
            eq_s = s1_mag_eq_q;
        end else begin
            lt_s = s1_mag_lt_q;
            eq_s = s1_mag_eq_q;
        end
        z_d = fp_predicate(s1_op_q, un_d, lt_s, eq_s);
`ifdef FP_CMP_INVALID_FLAG_EN
        inv_d = fp_invalid(s1_op_q, un_d, s1_cls_a_q.is_snan | s1_cls_b_q.is_snan);
`endif
    end

    // Result register plus delay stages; all cleared by reset and frozen by the stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= {(STAGES-1){1'b0}};
            res_z_q     <= {(STAGES-1){1'b0}};
            res_un_q    <= {(STAGES-1){1'b0}};
`ifdef FP_CMP_INVALID_FLAG_EN
            res_inv_q   <= {(STAGES-1){1'b0}};
`endif
        end else if (en_s) begin
            res_valid_q[2] <= s1_valid_q;
            res_z_q[2]     <= z_d;
            res_un_q[2]    <= un_d;
`ifdef FP_CMP_INVALID_FLAG_EN
            res_inv_q[2]   <= inv_d;
`endif
            for (int k = 3; k <= STAGES; k++) begin
                res_valid_q[k] <= res_valid_q[k-1];
                res_z_q[k]     <= res_z_q[k-1];
                res_un_q[k]    <= res_un_q[k-1];
`ifdef FP_CMP_INVALID_FLAG_EN
                res_inv_q[k]   <= res_inv_q[k-1];
`endif
            end
        end else begin
            res_valid_q <= res_valid_q;
            res_z_q     <= res_z_q;
            res_un_q    <= res_un_q;
`ifdef FP_CMP_INVALID_FLAG_EN
            res_inv_q   <= res_inv_q;
`endif
        end
    end

    assign out_valid     = res_valid_q[STAGES];
    assign out_z         = res_z_q[STAGES];
    assign out_unordered = res_un_q[STAGES];
`ifdef FP_CMP_INVALID_FLAG_EN
    assign out_invalid   = res_inv_q[STAGES];
`endif

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Scoreboard bench for fp_cmp_pipe: a single-precision instance (STAGES=2)
// and a double-precision instance (STAGES=4). Expected results come from a
// signed-key reference model and are queued at each input transfer.
module tb_fp_cmp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   lat_chk;

    typedef struct {
        logic [2:0] res;   // {inv, un, z}
        int         t_in;
        bit         chk;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_pop32 = 0;

    // Single-precision DUT
    logic        in_valid, in_ready, out_valid, out_ready, out_z, out_unordered, out_invalid;
    logic [31:0] in_a, in_b;
    logic [2:0]  in_op;

    // Double-precision DUT
    logic        v64, rdy64, ov64, ordy64, oz64, ou64, oinv64;
    logic [63:0] a64, b64;
    logic [2:0]  op64;

    fp_cmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_z(out_z), .out_unordered(out_unordered)
`ifdef FP_CMP_INVALID_FLAG_EN
        , .out_invalid(out_invalid)
`endif
    );

    fp_cmp_pipe #(.EXP_W(11), .MAN_W(52), .STAGES(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64),
        .in_a(a64), .in_b(b64), .in_op(op64), .out_valid(ov64),
        .out_ready(ordy64), .out_z(oz64), .out_unordered(ou64)
`ifdef FP_CMP_INVALID_FLAG_EN
        , .out_invalid(oinv64)
`endif
    );

`ifndef FP_CMP_INVALID_FLAG_EN
    assign out_invalid = 1'b0;
    assign oinv64      = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: order by a signed key (+/-magnitude), so +0 and -0 share key 0.
    function automatic logic [2:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input int ew, input int mw, input logic [2:0] op);
        logic [63:0] mmask, emask, ea, eb, ma, mb;
        logic        na, nb, sna, snb, un, lt, eq, z, inv;
        longint      ka, kb;
        mmask = (64'd1 << mw) - 64'd1;
        emask = (64'd1 << ew) - 64'd1;
        ma = a & mmask;
        mb = b & mmask;
        ea = (a >> mw) & emask;
        eb = (b >> mw) & emask;
        na  = (ea == emask) && (ma != 64'd0);
        nb  = (eb == emask) && (mb != 64'd0);
        sna = na && !ma[mw-1];
        snb = nb && !mb[mw-1];
        ka = longint'((ea << mw) | ma);
        kb = longint'((eb << mw) | mb);
        if (a[ew+mw]) ka = -ka;
        if (b[ew+mw]) kb = -kb;
        un = na || nb;
        lt = ka < kb;
        eq = ka == kb;
        case (op)
            3'd0:    z = !un && eq;
            3'd1:    z = un || !eq;
            3'd2:    z = !un && lt;
            3'd3:    z = !un && (lt || eq);
            3'd4:    z = !un && !lt && !eq;
            3'd5:    z = !un && !lt;
            3'd6:    z = un;
            default: z = !un;
        endcase
        inv = (op >= 3'd2 && op <= 3'd5) ? un : (sna || snb);
        return {inv, un, z};
    endfunction

    logic hold32 = 1'b0;
    logic hz, hu;

    // Single-precision monitor: hold stability, ordered pop/compare, push on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q32.delete();
            hold32 = 1'b0;
        end else begin
            if (hold32) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_z", out_z, hz);
                check("hold_un", out_unordered, hu);
            end
            if (out_valid && out_ready) begin
                if (q32.size() == 0) begin
                    check("stale32", out_valid, 1'b0);
                end else begin
                    e = q32.pop_front();
                    n_pop32++;
                    check("z32", out_z, e.res[0]);
                    check("un32", out_unordered, e.res[1]);
`ifdef FP_CMP_INVALID_FLAG_EN
                    check("inv32", out_invalid, e.res[2]);
`endif
                    if (e.chk) check("lat32", cyc - e.t_in, 2);
                end
            end
            hold32 = out_valid && !out_ready;
            hz = out_z;
            hu = out_unordered;
            if (in_valid && in_ready)
                q32.push_back('{model({32'd0, in_a}, {32'd0, in_b}, 8, 23, in_op), cyc, lat_chk});
        end
    end

    // Double-precision monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q64.delete();
        end else begin
            if (ov64 && ordy64) begin
                if (q64.size() == 0) begin
                    check("stale64", ov64, 1'b0);
                end else begin
                    e = q64.pop_front();
                    check("z64", oz64, e.res[0]);
                    check("un64", ou64, e.res[1]);
`ifdef FP_CMP_INVALID_FLAG_EN
                    check("inv64", oinv64, e.res[2]);
`endif
                    if (e.chk) check("lat64", cyc - e.t_in, 4);
                end
            end
            if (v64 && rdy64)
                q64.push_back('{model(a64, b64, 11, 52, op64), cyc, lat_chk});
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int i = 0;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        do begin
            @(negedge clk);
            i++;
        end while (!in_ready && i < 50);
        if (!in_ready) check("issue32_timeout", in_ready, 1'b1);
    endtask

    task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        int i = 0;
        @(posedge clk); #1;
        a64 = a; b64 = b; op64 = op; v64 = 1'b1;
        do begin
            @(negedge clk);
            i++;
        end while (!rdy64 && i < 50);
        if (!rdy64) check("issue64_timeout", rdy64, 1'b1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        v64 = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while ((q32.size() != 0 || q64.size() != 0) && i < 60) begin
            @(negedge clk);
            i++;
        end
        check("drain32", q32.size(), 0);
        check("drain64", q64.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = 32'd0; in_b = 32'd0; in_op = 3'd0;
        v64 = 1'b0; ordy64 = 1'b1; a64 = 64'd0; b64 = 64'd0; op64 = 3'd0;
        lat_chk = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_z", out_z, 1'b0);
        check("rst_out_un", out_unordered, 1'b0);
        check("rst_out_valid64", ov64, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        // Directed single-precision predicates, streaming back to back
        issue(32'h0000_0000, 32'h8000_0000, 3'd0);
        issue(32'h7FC0_0000, 32'h7FC0_0000, 3'd0);
        issue(32'h7FC0_0000, 32'h7FC0_0000, 3'd1);
        issue(32'h7FC0_0000, 32'h7FC0_0000, 3'd6);
        issue(32'h7FC0_0000, 32'h7FC0_0000, 3'd2);
        issue(32'hBF80_0000, 32'h3F80_0000, 3'd2);
        issue(32'hC000_0000, 32'hBF80_0000, 3'd2);
        issue(32'hBF80_0000, 32'h3F80_0000, 3'd4);
        issue(32'h3F80_0000, 32'h3F80_0000, 3'd3);
        issue(32'h0000_0001, 32'h0000_0000, 3'd4);
        issue(32'h7F80_0000, 32'h7F7F_FFFF, 3'd5);
        issue(32'h7F80_0001, 32'h3F80_0000, 3'd0);
        issue(32'hFF80_0000, 32'hFF7F_FFFF, 3'd2);
        issue(32'h8000_0001, 32'h0000_0000, 3'd2);
        issue(32'h7F80_0000, 32'h7F80_0000, 3'd0);
        issue(32'h3F80_0000, 32'hFFC0_0000, 3'd7);
        issue(32'h4000_0000, 32'h3F80_0000, 3'd7);
        idle();
        drain();

        // Backpressure: stall the consumer for 3 cycles after the first result
        lat_chk = 1'b0;
        n_pop32 = 0;
        fork
            begin
                issue(32'hBF80_0000, 32'h3F80_0000, 3'd2);
                issue(32'hBF80_0000, 32'h3F80_0000, 3'd4);
                issue(32'h0000_0001, 32'h0000_0000, 3'd4);
                issue(32'h0000_0000, 32'h8000_0000, 3'd1);
                idle();
            end
            begin
                int i = 0;
                do begin
                    @(negedge clk);
                    i++;
                end while (!out_valid && i < 50);
                check("bp_first_valid", out_valid, 1'b1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 1'b0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_pop32, 4);

        // Double precision
        lat_chk = 1'b1;
        issue64(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 3'd4);
        issue64(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'd0);
        issue64(64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'd6);
        issue64(64'hBFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'd2);
        issue64(64'h000F_FFFF_FFFF_FFFF, 64'h0010_0000_0000_0000, 3'd2);
        issue64(64'h7FF0_0000_0000_0000, 64'h7FEF_FFFF_FFFF_FFFF, 3'd4);
        idle();
        drain();

        // Reset mid-stream on both instances, two results in flight each
        issue(32'hBF80_0000, 32'h3F80_0000, 3'd2);
        issue(32'h3F80_0000, 32'h3F80_0000, 3'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_out_valid", out_valid, 1'b0);
        check("after_rst_in_ready", in_ready, 1'b1);
        repeat (4) @(negedge clk);
        issue(32'h3F80_0000, 32'h4000_0000, 3'd5);
        idle();
        drain();

        issue64(64'hBFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'd4);
        issue64(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        v64 = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready64", rdy64, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_out_valid64", ov64, 1'b0);
        repeat (6) @(negedge clk);
        issue64(64'hC000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 3'd2);
        idle();
        drain();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_cmp_pipe.md
Name: fp_cmp_pipe

Overview:
Pipelined, parametrised IEEE-754 comparator. It generalises the fixed single-precision not-equal block to any exponent/mantissa width and eight selectable predicates. It adds an unordered flag and a valid/ready handshake with backpressure. It sits beside the other float arithmetic units and feeds branch/select logic.

Parameters:
EXP_W, 8, exponent width in bits.
MAN_W, 23, stored mantissa width in bits (no hidden bit).
STAGES, 2, pipeline depth in cycles; legal range 2..4.
W (localparam), 1+EXP_W+MAN_W, operand width.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts this cycle
in_a  in  W  operand A (sign, exponent, mantissa)
in_b  in  W  operand B
in_op  in  3  predicate: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 UN, 7 ORD
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_z  out  1  predicate result (A op B)
out_unordered  out  1  either operand is NaN

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Classification per operand:
  - NaN: exponent all-ones and mantissa != 0.
  - Zero: exponent 0 and mantissa 0.
  - Infinity: exponent all-ones and mantissa 0; compares as an ordinary magnitude.
  - Denormals are compared exactly; no flush-to-zero.
- Ordered relation (no NaN present):
  - Both zero: equal, regardless of sign (+0 == -0).
  - Signs differ: the negative operand is less.
  - Same sign: compare {exp,man} unsigned; invert the result when both are negative.
- Predicates with any NaN operand: EQ, LT, LE, GT, GE give 0; NE gives 1; UN gives 1; ORD gives 0.
- Pipeline:
  - Stage 1 registers classification, sign, the magnitude compare (lt/eq) and op.
  - The final stage registers out_z and out_unordered.
  - Stages 3..STAGES are pure delay registers carrying a valid bit.
- Handshake:
  - Global enable en = !out_valid | out_ready; in_ready = en & !rst.
  - A transfer occurs when in_valid & in_ready. When en=0, every stage holds.
  - Throughput is 1 result per cycle. Latency is STAGES cycles from input transfer to out_valid when there is no backpressure.
  - Results leave in input order. out_z and out_unordered stay stable while out_valid & !out_ready.
- Reset:
  - Applies to all stage valid bits, out_valid, out_z and out_unordered, which all go to 0. Other data registers are not reset.
  - Reset mid-stream discards in-flight results; none emerge afterwards.
  - in_ready=0 in the cycle rst is high and 1 the cycle after.
- Bubbles: when in_valid=0 with en=1, a bubble (valid=0) enters the pipe.

Optional Feature:
Macro FP_CMP_INVALID_FLAG_EN.
- Defined:
  - Adds port out_invalid (out, 1), pipelined alongside out_z and reset to 0.
  - Set for LT/LE/GT/GE when any operand is NaN.
  - Set for EQ/NE/UN/ORD only when any operand is a signalling NaN (mantissa MSB = 0).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fp_cmp_pkg holds:
  - the op code localparams (OP_EQ..OP_ORD);
  - a 3-bit op typedef;
  - a classification struct (is_nan, is_snan, is_zero, sign).
- One sub-module, fp_classify: combinational, parametrised by EXP_W/MAN_W, instanced once per operand.
- Stage registers live in fp_cmp_pipe. The existing enable-less delay line is not reusable because it has no enable or reset.

Test Plan:
1. EQ, A=0x00000000, B=0x80000000, out_ready=1 → out_z=1, out_unordered=0, exactly 2 cycles after transfer.
2. A=B=0x7FC00000 → EQ gives 0, NE gives 1, UN gives 1 (out_unordered=1 each time). With FP_CMP_INVALID_FLAG_EN, out_invalid=0 for EQ; LT with the same operands gives out_invalid=1.
3. LT: 0xBF800000 vs 0x3F800000 → 1; 0xC0000000 vs 0xBF800000 → 1; GT on the first pair → 0; LE with A=B=0x3F800000 → 1.
4. GT: 0x00000001 vs 0x00000000 → 1; GE: 0x7F800000 vs 0x7F7FFFFF → 1. Repeat with EXP_W=11, MAN_W=52: 0x0000000000000001 GT 0 → 1.
5. Backpressure: issue 4 back-to-back ops, hold out_ready=0 for 3 cycles after the first out_valid → in_ready drops, out_z is held stable, all 4 results arrive in order with none lost or duplicated.
6. Reset mid-stream: assert rst for 1 cycle with 2 results in flight → out_valid=0 next cycle, no stale result ever appears, and a new op issued after reset returns correctly in STAGES cycles (also run with STAGES=4).
